// File: rtl/neuron_pkg.sv
// Shared types for the neuron MAC: FSM state encoding and activation-mode codes.
package neuron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

    localparam logic ACT_IDENTITY = 1'b0;
    localparam logic ACT_RELU     = 1'b1;

endpackage

// File: rtl/neuron_sat_act.sv
// Output stage: fixed-point rescale of the accumulator, clamp to DATA_W, optional ReLU.
module neuron_sat_act
    import neuron_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 19,
    parameter int FRAC_SHIFT = 8
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic                     act_mode,
    output logic signed [DATA_W-1:0] y,
    output logic                     sat
);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic signed [ACC_W-1:0]  shifted;
    logic signed [DATA_W-1:0] clamped;

    // out_sat reflects clamping only; ReLU zeroing never counts as saturation.
    always_comb begin
        shifted = acc >>> FRAC_SHIFT;
        sat     = 1'b0;
        clamped = DATA_W'(shifted);
        if (shifted > MAX_V) begin
            clamped = DATA_W'(MAX_V);
            sat     = 1'b1;
        end else if (shifted < MIN_V) begin
            clamped = DATA_W'(MIN_V);
            sat     = 1'b1;
        end
        y = ((act_mode == ACT_RELU) && clamped[DATA_W-1]) ? '0 : clamped;
    end

endmodule

// File: rtl/neuron_mac.sv
// Single neuron: accumulates N_INPUTS x*weight beats on top of a scaled bias,
// then presents one saturated, activated result with a valid/ready handshake.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int N_INPUTS   = 4,
    parameter int FRAC_SHIFT = 8,
    parameter int ACC_W      = 2*DATA_W + $clog2(N_INPUTS) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] weight,
    input  logic signed [DATA_W-1:0] bias,
    input  logic                     act_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] y,
    output logic                     out_sat
);

    localparam int CNT_W = $clog2(N_INPUTS + 1);

    state_t                    state;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_base;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [2*DATA_W-1:0] prod;
    logic [CNT_W-1:0]          cnt;
    logic                      act_lat;
    logic                      act_eff;
    logic                      accept;
    logic                      last_beat;
    logic signed [DATA_W-1:0]  y_next;
    logic                      sat_next;

    assign in_ready  = (state != ST_OUT);
    assign out_valid = (state == ST_OUT);
    assign accept    = in_valid && in_ready;

    // The first beat of a frame seeds the accumulator with the bias in the product's fixed-point scale.
    always_comb begin
        prod      = x * weight;
        acc_base  = (state == ST_IDLE) ? (ACC_W'(bias) <<< FRAC_SHIFT) : acc;
        acc_next  = acc_base + ACC_W'(prod);
        act_eff   = (state == ST_IDLE) ? act_mode : act_lat;
        last_beat = (state == ST_ACCUM) && (cnt == CNT_W'(N_INPUTS - 1));
    end

    neuron_sat_act #(
        .DATA_W     (DATA_W),
        .ACC_W      (ACC_W),
        .FRAC_SHIFT (FRAC_SHIFT)
    ) u_sat_act (
        .acc      (acc_next),
        .act_mode (act_eff),
        .y        (y_next),
        .sat      (sat_next)
    );

    // y/out_sat are captured from the final beat's sum so the result is ready one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            acc     <= '0;
            cnt     <= '0;
            act_lat <= ACT_IDENTITY;
            y       <= '0;
            out_sat <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        acc     <= acc_next;
                        act_lat <= act_mode;
                        cnt     <= CNT_W'(1);
                        state   <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        acc <= acc_next;
                        cnt <= cnt + CNT_W'(1);
                        if (last_beat) begin
                            y       <= y_next;
                            out_sat <= sat_next;
                            state   <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: per-cycle arithmetic model plus directed literal vectors.
module tb_neuron_mac;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int FS = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [7:0] x = '0;
    logic signed [7:0] weight = '0;
    logic signed [7:0] bias = '0;
    logic              act_mode = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic signed [7:0] y;
    logic              out_sat;

    int vectors     = 0;
    int miscompares = 0;

    bit                m_have_out = 1'b0;
    int                m_beats    = 0;
    longint            m_sum      = 0;
    bit                m_act      = 1'b0;
    logic signed [7:0] m_y        = '0;
    bit                m_sat      = 1'b0;

    neuron_mac #(
        .DATA_W     (DW),
        .N_INPUTS   (N),
        .FRAC_SHIFT (FS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .weight    (weight),
        .bias      (bias),
        .act_mode  (act_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic compareValue(input string name, input logic signed [31:0] actual,
                                input logic signed [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Plain fixed-point arithmetic: floor-divide by 2^FS, clamp to int8, optional ReLU.
    function automatic void modelResult(input longint sum, input bit act,
                                        output logic signed [7:0] ry, output bit rs);
        longint q = sum >>> FS;
        rs = 1'b0;
        if (q > 127) begin
            q  = 127;
            rs = 1'b1;
        end else if (q < -128) begin
            q  = -128;
            rs = 1'b1;
        end
        if (act && q < 0) q = 0;
        ry = 8'(q);
    endfunction

    // Inputs are stable at the falling edge: check outputs, then predict the next rising edge.
    always @(negedge clk) begin
        compareValue("model_out_valid", {31'd0, out_valid}, {31'd0, m_have_out});
        compareValue("model_in_ready", {31'd0, in_ready}, {31'd0, !m_have_out});
        if (m_have_out) begin
            compareValue("model_y", y, m_y);
            compareValue("model_out_sat", {31'd0, out_sat}, {31'd0, m_sat});
        end
        if (rst) begin
            m_have_out = 1'b0;
            m_beats    = 0;
            m_sum      = 0;
        end else if (m_have_out) begin
            if (out_ready) m_have_out = 1'b0;
        end else if (in_valid) begin
            if (m_beats == 0) begin
                m_sum = longint'(bias) * (longint'(1) << FS);
                m_act = act_mode;
            end
            m_sum += longint'(x) * longint'(weight);
            m_beats++;
            if (m_beats == N) begin
                modelResult(m_sum, m_act, m_y, m_sat);
                m_have_out = 1'b1;
                m_beats    = 0;
            end
        end
    end

    // One frame of N identical beats, optionally with idle cycles after the second beat.
    task automatic applyStimulus(input logic signed [7:0] xv, input logic signed [7:0] wv,
                                 input logic signed [7:0] bv, input logic av, input int gap);
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            x        = xv;
            weight   = wv;
            bias     = bv;
            act_mode = av;
            @(posedge clk);
            #1;
            if (i == 1 && gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    // Called one cycle after the last beat: the result must already be valid, then it is consumed.
    task automatic checkOutput(input string name, input int ey, input int esat);
        out_ready = 1'b1;
        @(negedge clk);
        compareValue({name, "_out_valid"}, {31'd0, out_valid}, 1);
        compareValue({name, "_y"}, y, ey);
        compareValue({name, "_out_sat"}, {31'd0, out_sat}, esat);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic checkReset(input string name);
        @(negedge clk);
        compareValue({name, "_out_valid"}, {31'd0, out_valid}, 0);
        compareValue({name, "_y"}, y, 0);
        compareValue({name, "_out_sat"}, {31'd0, out_sat}, 0);
        compareValue({name, "_in_ready"}, {31'd0, in_ready}, 1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkReset("reset");

        applyStimulus(8'sd64, 8'sd64, 8'sd0, 1'b0, 0);
        checkOutput("basic", 64, 0);

        applyStimulus(8'sd64, 8'sd64, 8'sd10, 1'b0, 2);
        checkOutput("bias_gap", 74, 0);

        applyStimulus(8'sd127, 8'sd127, 8'sd0, 1'b0, 0);
        checkOutput("sat_pos", 127, 1);

        applyStimulus(-8'sd128, 8'sd127, 8'sd0, 1'b0, 0);
        checkOutput("sat_neg", -128, 1);

        applyStimulus(-8'sd64, 8'sd64, 8'sd0, 1'b1, 0);
        checkOutput("relu", 0, 0);

        applyStimulus(-8'sd64, 8'sd64, 8'sd0, 1'b0, 0);
        checkOutput("identity_neg", -64, 0);

        applyStimulus(-8'sd1, 8'sd1, 8'sd0, 1'b0, 0);
        checkOutput("floor", -1, 0);

        applyStimulus(8'sd127, 8'sd127, 8'sd0, 1'b1, 0);
        checkOutput("relu_sat_pos", 127, 1);

        applyStimulus(-8'sd128, 8'sd127, 8'sd0, 1'b1, 0);
        checkOutput("relu_sat_neg", 0, 1);

        // Backpressure: beats offered while the result is held must be ignored.
        applyStimulus(8'sd64, 8'sd64, 8'sd0, 1'b0, 0);
        in_valid = 1'b1;
        x        = 8'sd5;
        weight   = 8'sd5;
        bias     = 8'sd3;
        repeat (3) begin
            @(negedge clk);
            compareValue("stall_in_ready", {31'd0, in_ready}, 0);
            compareValue("stall_y", y, 64);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkOutput("stall", 64, 0);
        applyStimulus(8'sd32, 8'sd16, -8'sd2, 1'b0, 0);
        checkOutput("after_stall", 6, 0);

        // Reset in the middle of a frame, with a beat still offered during reset.
        in_valid = 1'b1;
        x        = 8'sd100;
        weight   = 8'sd100;
        bias     = 8'sd50;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        checkReset("mid_reset");
        applyStimulus(8'sd64, 8'sd64, 8'sd0, 1'b0, 0);
        checkOutput("post_reset", 64, 0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
